// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
// The master offers tx_data with tx_valid; the slave answers with tx_ready.
interface uart_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per frame, LSB first, idle-high line.
// Bit timing comes from an integer clocks-per-bit counter with no fractional correction.
module uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      tx_busy,
    output logic      tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [CNT_W-1:0] baud_d;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             baud_last;

    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latch is inferred.
        baud_last = (baud_q == BAUD_LAST);
        baud_d    = baud_last ? '0 : baud_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (bus.tx_valid && ready_q) begin
                        shift_q <= bus.tx_data;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end

                START: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= DATA;
                    end
                end

                DATA: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end

                STOP: begin
                    baud_q <= baud_d;
                    // Frame ends here; ready rises so a held tx_valid is taken on the next edge.
                    if (baud_last) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready = ready_q;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: the driver queues each accepted byte with its accept cycle,
// and line monitors compare every clock of the frame against a bit-level frame model.
module tb_uart_tx;
    localparam int CPB  = 4;                   // CLK_FREQ=40, BAUD=10
    localparam int CPB6 = 50_000_000 / 9600;   // default parameters

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if bus ();
    uart_tx_if bus6 ();
    logic tx, tx_busy, tx_done;
    logic tx6, tx_busy6, tx_done6;

    uart_tx #(.CLK_FREQ(40), .BAUD(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    uart_tx dut6 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus6),
        .tx      (tx6),
        .tx_busy (tx_busy6),
        .tx_done (tx_done6)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         k;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp6_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   in_frame = 1'b0;
    bit   done6_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected line level i clocks after the accept edge: start, 8 data bits LSB first, stop.
    function automatic logic frame_level(input logic [7:0] d, input int i, input int cpb);
        int b;
        logic [7:0] v;
        b = i / cpb;
        v = d;
        if (b == 0) return 1'b0;
        if (b <= 8) return v[b-1];
        return 1'b1;
    endfunction

    task automatic run_frame(input exp_t e);
        in_frame = 1'b1;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (rst) begin
                in_frame = 1'b0;
                return;
            end
            check("frame_tx", 32'(tx), 32'(frame_level(e.data, i, CPB)));
            check("frame_flags", {29'd0, bus.tx_ready, tx_busy, tx_done}, 32'b010);
            @(negedge clk);
        end
        if (!rst)
            check("done_edge", {28'd0, bus.tx_ready, tx_busy, tx_done, tx}, 32'b1011);
        in_frame = 1'b0;
    endtask

    // Monitor for the small-divider instance: frames at their accept cycle, idle checks otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].k == cyc)
                run_frame(exp_q.pop_front());
            else
                check("idle", {28'd0, tx, bus.tx_ready, tx_busy, tx_done}, 32'b1100);
        end
    end

    // Monitor for the default-parameter instance: level-exact compare plus mid-bit decode.
    initial begin
        exp_t       e;
        int         errs;
        logic [7:0] dec;
        forever begin
            @(negedge clk);
            if (exp6_q.size() > 0 && exp6_q[0].k == cyc) begin
                e    = exp6_q.pop_front();
                errs = 0;
                dec  = 8'h00;
                for (int i = 0; i < 10 * CPB6; i++) begin
                    if (tx6 !== frame_level(e.data, i, CPB6) || tx_done6 !== 1'b0) errs++;
                    if (i % CPB6 == CPB6 / 2 && i / CPB6 >= 1 && i / CPB6 <= 8)
                        dec[i/CPB6-1] = tx6;
                    @(negedge clk);
                end
                check("dflt_levels", 32'(errs), 32'd0);
                check("dflt_decode", {24'd0, dec}, {24'd0, e.data});
                check("dflt_done", {30'd0, tx_done6, tx6}, 32'b11);
                done6_seen = 1'b1;
            end
        end
    end

    // Called at a negedge; returns just after the accept edge with tx_valid dropped.
    task automatic send(input logic [7:0] d, output int k);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        k = -1;
        for (int t = 0; t < 200; t++) begin
            if (bus.tx_ready === 1'b1 && !rst) begin
                k = cyc + 1;
                exp_q.push_back('{d, k});
                break;
            end
            @(negedge clk);
        end
        if (k < 0) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 500; t++) begin
            if (exp_q.size() == 0 && !in_frame) break;
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()) + 32'(in_frame), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int k;
        int k1;
        int k2;

        bus.tx_valid  = 1'b1;
        bus.tx_data   = 8'h55;
        bus6.tx_valid = 1'b0;
        bus6.tx_data  = 8'h00;
        rst           = 1'b1;

        // 1: reset with tx_valid held high; first accept on the first non-reset edge
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {28'd0, tx, bus.tx_ready, tx_busy, tx_done}, 32'b1100);
        rst = 1'b0;
        send(8'h55, k);
        check("rst_first_accept", 32'(k), 32'd4);
        wait_idle();

        // 2: single byte
        send(8'hA5, k);
        wait_idle();

        // 3: back-to-back with tx_valid reasserted immediately
        send(8'h00, k1);
        @(negedge clk);
        send(8'hFF, k2);
        check("b2b_gap", 32'(k2 - k1), 32'd41);
        wait_idle();

        // 4: tx_valid pulse and data churn while busy
        send(8'h3C, k);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus.tx_valid = (cyc == k + 9 || cyc == k + 10);
            bus.tx_data  = bus.tx_valid ? 8'hFF : 8'($urandom);
        end
        bus.tx_valid = 1'b0;
        wait_idle();

        // 5: reset inside bit 3, then a clean frame
        send(8'h81, k);
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", {30'd0, tx, tx_done}, 32'b10);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h42, k);
        wait_idle();

        // random bytes with random gaps, including zero-gap back-to-back
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(8'($urandom), k);
            @(negedge clk);
        end
        wait_idle();

        // 6: default parameters
        bus6.tx_valid = 1'b1;
        bus6.tx_data  = 8'h5A;
        check("dflt_ready", 32'(bus6.tx_ready), 32'd1);
        exp6_q.push_back('{8'h5A, cyc + 1});
        @(posedge clk);
        #1 bus6.tx_valid = 1'b0;
        for (int t = 0; t < 10 * CPB6 + 100; t++) begin
            if (done6_seen) break;
            @(negedge clk);
        end
        check("dflt_finished", 32'(done6_seen), 32'd1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
